// File: rtl/round_key_sequencer.sv
// AES-128 round-key store and sequencer: registers the cipher key feeding the
// key expander, captures the settled schedule, and streams round keys on demand.
module round_key_sequencer (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [127:0]  key_in,
    input  logic          key_load,
    output logic [127:0]  key_out,
    input  logic [1407:0] expanded_key_in,
    output logic          key_valid,
    input  logic          start,
    input  logic          decrypt,
    output logic [127:0]  rk_out,
    output logic [3:0]    rk_idx,
    output logic          rk_valid,
    input  logic          rk_ready,
    output logic          done
);

    typedef enum logic [1:0] {
        EMPTY,
        SETTLE,
        READY,
        STREAM
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'd10;

    state_t          state_q,     state_d;
    logic [127:0]    key_q,       key_d;
    logic [1407:0]   sched_q,     sched_d;
    logic            key_valid_q, key_valid_d;
    logic [127:0]    rk_out_q,    rk_out_d;
    logic [3:0]      rk_idx_q,    rk_idx_d;
    logic            rk_valid_q,  rk_valid_d;
    logic            dir_q,       dir_d;
    logic            done_q,      done_d;
    logic            last_key;

    // Round 0 sits in the top 128 bits of the schedule, round 10 in the bottom.
    function automatic logic [127:0] round_key(input logic [1407:0] sched,
                                               input logic [3:0]    idx);
        logic [10:0] base;
        base = {LAST_IDX - idx, 7'd0};
        return sched[base +: 128];
    endfunction

    assign last_key = dir_q ? (rk_idx_q == 4'd0) : (rk_idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= EMPTY;
            key_q       <= '0;
            sched_q     <= '0;
            key_valid_q <= 1'b0;
            rk_out_q    <= '0;
            rk_idx_q    <= '0;
            rk_valid_q  <= 1'b0;
            dir_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            sched_q     <= sched_d;
            key_valid_q <= key_valid_d;
            rk_out_q    <= rk_out_d;
            rk_idx_q    <= rk_idx_d;
            rk_valid_q  <= rk_valid_d;
            dir_q       <= dir_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        sched_d     = sched_q;
        key_valid_d = key_valid_q;
        rk_out_d    = rk_out_q;
        rk_idx_d    = rk_idx_q;
        rk_valid_d  = rk_valid_q;
        dir_d       = dir_q;
        done_d      = 1'b0;

        // A load pre-empts everything, including a stream in flight and a start.
        if (key_load) begin
            state_d     = SETTLE;
            key_d       = key_in;
            key_valid_d = 1'b0;
            rk_valid_d  = 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                end
                SETTLE: begin
                    // The expander has had one full cycle on key_q; its output is stable now.
                    sched_d     = expanded_key_in;
                    key_valid_d = 1'b1;
                    state_d     = READY;
                end
                READY: begin
                    if (start) begin
                        state_d    = STREAM;
                        dir_d      = decrypt;
                        rk_idx_d   = decrypt ? LAST_IDX : 4'd0;
                        rk_out_d   = round_key(sched_q, rk_idx_d);
                        rk_valid_d = 1'b1;
                    end
                end
                STREAM: begin
                    if (rk_ready) begin
                        if (last_key) begin
                            state_d    = READY;
                            rk_valid_d = 1'b0;
                            done_d     = 1'b1;
                        end else begin
                            rk_idx_d = dir_q ? (rk_idx_q - 4'd1) : (rk_idx_q + 4'd1);
                            rk_out_d = round_key(sched_q, rk_idx_d);
                        end
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign key_out   = key_q;
    assign key_valid = key_valid_q;
    assign rk_out    = rk_out_q;
    assign rk_idx    = rk_idx_q;
    assign rk_valid  = rk_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_round_key_sequencer.sv
// Bench for round_key_sequencer: behavioural AES-128 expander attached to the DUT,
// known-answer vector table, hand-written corner sequences and a random run vs a queue model.
module tb_round_key_sequencer;

    logic          clk = 1'b0;
    logic          n_rst;
    logic [127:0]  key_in;
    logic          key_load;
    logic [127:0]  key_out;
    logic [1407:0] expanded_key_in;
    logic          key_valid;
    logic          start;
    logic          decrypt;
    logic [127:0]  rk_out;
    logic [3:0]    rk_idx;
    logic          rk_valid;
    logic          rk_ready;
    logic          done;

    int checks = 0;
    int failures = 0;

    localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2RA = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    round_key_sequencer dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .key_in          (key_in),
        .key_load        (key_load),
        .key_out         (key_out),
        .expanded_key_in (expanded_key_in),
        .key_valid       (key_valid),
        .start           (start),
        .decrypt         (decrypt),
        .rk_out          (rk_out),
        .rk_idx          (rk_idx),
        .rk_valid        (rk_valid),
        .rk_ready        (rk_ready),
        .done            (done)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural AES-128 key expansion ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] s;
        logic [7:0] inv;
        logic [7:0] r;
        // x^254 = product of x^(2^k), k = 1..7
        s = x; inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            s = gmul(s, s);
            inv = gmul(inv, s);
        end
        r = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return r;
    endfunction

    function automatic logic [1407:0] expand_key(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
                rc = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end
            w[i] = w[i-4] ^ t;
        end
        res = '0;
        for (int r = 0; r < 11; r++)
            res[1407 - 128*r -: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return res;
    endfunction

    assign expanded_key_in = expand_key(key_out);

    // ---------------- reference model ----------------
    logic [127:0] m_keyout;
    logic [127:0] m_rk [11];
    bit           m_settle;
    bit           m_kv;
    bit           m_done;
    int           m_q [$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_keyout = '0;
        m_settle = 0;
        m_kv = 0;
        m_done = 0;
        m_q.delete();
        for (int r = 0; r < 11; r++) m_rk[r] = '0;
    endtask

    task automatic model_edge();
        logic [1407:0] e;
        m_done = 0;
        if (key_load) begin
            m_keyout = key_in;
            m_settle = 1;
            m_kv = 0;
            m_q.delete();
        end else if (m_settle) begin
            e = expand_key(m_keyout);
            for (int r = 0; r < 11; r++) m_rk[r] = e[1407 - 128*r -: 128];
            m_settle = 0;
            m_kv = 1;
        end else if (m_q.size() != 0) begin
            if (rk_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_done = 1;
            end
        end else if (m_kv && start) begin
            for (int r = 0; r < 11; r++) m_q.push_back(decrypt ? 10 - r : r);
        end
    endtask

    task automatic model_check();
        chk("m_key_out",   key_out,         m_keyout);
        chk("m_key_valid", 128'(key_valid), 128'(m_kv));
        chk("m_rk_valid",  128'(rk_valid),  128'(m_q.size() != 0));
        chk("m_done",      128'(done),      128'(m_done));
        if (m_q.size() != 0) begin
            chk("m_rk_idx", 128'(rk_idx), 128'(m_q[0]));
            chk("m_rk_out", rk_out,       m_rk[m_q[0]]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        model_check();
    endtask

    task automatic set_in(input bit ld, input logic [127:0] k, input bit st,
                          input bit dec, input bit rdy);
        key_load = ld; key_in = k; start = st; decrypt = dec; rk_ready = rdy;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit           ld;
        logic [127:0] key;
        bit           st;
        bit           dec;
        bit           rdy;
        bit           kv;
        bit           rkv;
        logic [3:0]   idx;
        bit           dn;
        bit           chk_rk;
        logic [127:0] rk;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(bit ld, logic [127:0] key, bit st, bit dec, bit rdy,
                                bit kv, bit rkv, int idx, bit dn, bit chk_rk, logic [127:0] rk);
        vec_t v;
        v.ld = ld; v.key = key; v.st = st; v.dec = dec; v.rdy = rdy;
        v.kv = kv; v.rkv = rkv; v.idx = 4'(idx); v.dn = dn; v.chk_rk = chk_rk; v.rk = rk;
        return v;
    endfunction

    initial begin
        // Load K1, encrypt stream with rk_ready high, then decrypt with rk_ready toggling.
        tbl.push_back(mk(1, K1, 0, 0, 0,  0, 0, 0, 0, 0, '0));
        tbl.push_back(mk(0, '0, 0, 0, 0,  1, 0, 0, 0, 0, '0));
        tbl.push_back(mk(0, '0, 1, 0, 1,  1, 1, 0, 0, 1, K1));
        for (int i = 1; i <= 10; i++)
            tbl.push_back(mk(0, '0, (i == 4), (i == 4), 1, 1, 1, i, 0,
                             (i == 1 || i == 10), (i == 1) ? K1R1 : K1RA));
        tbl.push_back(mk(0, '0, 0, 0, 1,  1, 0, 0, 1, 0, '0));
        tbl.push_back(mk(0, '0, 0, 0, 0,  1, 0, 0, 0, 0, '0));
        tbl.push_back(mk(0, '0, 1, 1, 0,  1, 1, 10, 0, 1, K1RA));
        for (int n = 10; n >= 1; n--) begin
            tbl.push_back(mk(0, '0, 0, 0, 1, 1, 1, n - 1, 0, 0, '0));
            tbl.push_back(mk(0, '0, 0, 0, 0, 1, 1, n - 1, 0, (n == 1), K1));
        end
        tbl.push_back(mk(0, '0, 0, 0, 1,  1, 0, 0, 1, 0, '0));
        tbl.push_back(mk(0, '0, 0, 0, 0,  1, 0, 0, 0, 0, '0));

        n_rst = 1'b0;
        set_in(0, '0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_key_out",   key_out,         '0);
        chk("rst_key_valid", 128'(key_valid), '0);
        chk("rst_rk_out",    rk_out,          '0);
        chk("rst_rk_idx",    128'(rk_idx),    '0);
        chk("rst_rk_valid",  128'(rk_valid),  '0);
        chk("rst_done",      128'(done),      '0);
        n_rst = 1'b1;

        // Start while EMPTY is ignored.
        set_in(0, '0, 1, 0, 1);
        step();
        chk("empty_start_rkv", 128'(rk_valid), '0);

        foreach (tbl[i]) begin
            set_in(tbl[i].ld, tbl[i].key, tbl[i].st, tbl[i].dec, tbl[i].rdy);
            step();
            chk($sformatf("tbl%0d_kv", i),   128'(key_valid), 128'(tbl[i].kv));
            chk($sformatf("tbl%0d_rkv", i),  128'(rk_valid),  128'(tbl[i].rkv));
            chk($sformatf("tbl%0d_done", i), 128'(done),      128'(tbl[i].dn));
            if (tbl[i].rkv) chk($sformatf("tbl%0d_idx", i), 128'(rk_idx), 128'(tbl[i].idx));
            if (tbl[i].chk_rk) chk($sformatf("tbl%0d_rk", i), rk_out, tbl[i].rk);
        end
        chk("key_out_k1", key_out, K1);

        // Abort at idx 5 with a new key load; start during SETTLE is dropped.
        set_in(0, '0, 1, 0, 1);
        step();
        set_in(0, '0, 0, 0, 1);
        repeat (5) step();
        chk("abort_idx5", 128'(rk_idx), 128'(5));
        set_in(1, K2, 0, 0, 1);
        step();
        chk("abort_rkv",  128'(rk_valid),  '0);
        chk("abort_kv",   128'(key_valid), '0);
        chk("abort_done", 128'(done),      '0);
        chk("abort_key",  key_out,         K2);
        set_in(0, '0, 1, 0, 1);
        step();
        chk("settle_start_rkv", 128'(rk_valid),  '0);
        chk("settle_kv",        128'(key_valid), 128'(1));
        // key_load together with start in READY: the load wins.
        set_in(1, K2, 1, 1, 0);
        step();
        chk("ldst_rkv", 128'(rk_valid),  '0);
        chk("ldst_kv",  128'(key_valid), '0);
        set_in(0, '0, 0, 0, 0);
        step();
        chk("ldst_settled_rkv", 128'(rk_valid), '0);
        set_in(0, '0, 1, 1, 0);
        step();
        chk("k2_first_idx", 128'(rk_idx), 128'(10));
        chk("k2_idx10_key", rk_out,       K2RA);

        // Asynchronous reset between edges in the middle of a stream.
        set_in(0, '0, 0, 0, 1);
        repeat (3) step();
        #2;
        n_rst = 1'b0;
        #1;
        chk("arst_key_out",   key_out,         '0);
        chk("arst_key_valid", 128'(key_valid), '0);
        chk("arst_rk_out",    rk_out,          '0);
        chk("arst_rk_idx",    128'(rk_idx),    '0);
        chk("arst_rk_valid",  128'(rk_valid),  '0);
        chk("arst_done",      128'(done),      '0);
        model_reset();
        @(negedge clk);
        n_rst = 1'b1;
        set_in(0, '0, 1, 0, 1);
        step();
        chk("post_rst_start_rkv", 128'(rk_valid), '0);
        chk("post_rst_done",      128'(done),     '0);

        // Random traffic against the queue model.
        for (int c = 0; c < 600; c++) begin
            set_in(($urandom_range(0, 99) < 3),
                   {$urandom, $urandom, $urandom, $urandom},
                   ($urandom_range(0, 99) < 25),
                   1'($urandom_range(0, 1)),
                   ($urandom_range(0, 99) < 60));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
